// File: rtl/digest_framer.sv
// Reads a RAM-resident digest byte by byte and emits it as a framed valid/ready byte stream.
// Optional CAN CRC-15 per frame is enabled by defining FRAMER_CRC_EN.
module digest_framer #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned DIGEST_BYTES = 32,
  parameter int unsigned FRAME_BYTES  = 8,
  parameter int unsigned RD_LATENCY   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addrToDigest,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memOutEn,
  input  logic [DATA_WIDTH-1:0] memData,
  output logic [DATA_WIDTH-1:0] outData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic                  outFirst,
  output logic                  outLast,
  output logic [1:0]            frameNum,
  output logic                  busy,
  output logic                  finish,
  output logic [14:0]           crcOut,
  output logic                  crcValid
);

  localparam int unsigned IDX_W = $clog2(DIGEST_BYTES);
  localparam int unsigned LAT_W = 2;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_PRESENT, S_DONE} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [IDX_W-1:0]      r_idx;
  logic [LAT_W-1:0]      r_lat;
  int unsigned           w_pos;
  int unsigned           w_frame;

  assign w_pos   = 32'(r_idx) % FRAME_BYTES;
  assign w_frame = 32'(r_idx) / FRAME_BYTES;

  // Sequencer: one RAM read per byte, then hold the byte until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_base   <= '0;
      r_idx    <= '0;
      r_lat    <= '0;
      memAddr  <= '0;
      memOutEn <= 1'b0;
      outData  <= '0;
      outValid <= 1'b0;
      outFirst <= 1'b0;
      outLast  <= 1'b0;
      frameNum <= '0;
      busy     <= 1'b0;
      finish   <= 1'b0;
    end else begin
      memOutEn <= 1'b0;
      finish   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base  <= addrToDigest;
            r_idx   <= '0;
            busy    <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          memAddr  <= r_base + ADDR_WIDTH'(r_idx);
          memOutEn <= 1'b1;
          r_lat    <= '0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (r_lat == LAT_W'(RD_LATENCY - 1)) begin
            outData  <= memData;
            outValid <= 1'b1;
            outFirst <= (w_pos == 0);
            outLast  <= (w_pos == FRAME_BYTES - 1);
            frameNum <= 2'(w_frame);
            r_state  <= S_PRESENT;
          end else begin
            r_lat <= r_lat + LAT_W'(1);
          end
        end
        S_PRESENT: begin
          if (outReady) begin
            outValid <= 1'b0;
            if (r_idx == IDX_W'(DIGEST_BYTES - 1)) begin
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          finish  <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef FRAMER_CRC_EN
  logic [14:0] r_crc_acc;
  logic [14:0] w_crc_next;

  function automatic logic [14:0] crc15_byte(input logic [14:0] c, input logic [DATA_WIDTH-1:0] d);
    logic [14:0] r;
    logic        nxt;
    r = c;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      nxt = r[14] ^ d[i];
      r   = {r[13:0], 1'b0};
      if (nxt) r = r ^ 15'h4599;
    end
    return r;
  endfunction

  // The first byte of a frame restarts the accumulator from zero.
  assign w_crc_next = crc15_byte(outFirst ? 15'd0 : r_crc_acc, outData);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_crc_acc <= '0;
      crcOut    <= '0;
      crcValid  <= 1'b0;
    end else begin
      crcValid <= 1'b0;
      if (outValid && outReady) begin
        r_crc_acc <= w_crc_next;
        if (outLast) begin
          crcOut   <= w_crc_next;
          crcValid <= 1'b1;
        end
      end
    end
  end
`else
  assign crcOut   = '0;
  assign crcValid = 1'b0;
`endif

endmodule

// File: tb/tb_digest_framer.sv
// Directed bench for digest_framer: table-driven byte checks plus stall, wrap, reset, held-start,
// latency-3 and CRC sequences.
module tb_digest_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  addrToDigest = '0;
  logic [9:0]  memAddr;
  logic        memOutEn;
  logic [7:0]  memData;
  logic [7:0]  outData;
  logic        outValid;
  logic        outReady = 1'b1;
  logic        outFirst, outLast;
  logic [1:0]  frameNum;
  logic        busy, finish;
  logic [14:0] crcOut;
  logic        crcValid;

  logic        start3 = 1'b0;
  logic [9:0]  memAddr3;
  logic        memOutEn3;
  logic [7:0]  memData3;
  logic [7:0]  outData3;
  logic        outValid3;
  logic        outReady3 = 1'b1;
  logic        outFirst3, outLast3;
  logic [1:0]  frameNum3;
  logic        busy3, finish3;
  logic [14:0] crcOut3;
  logic        crcValid3;

  digest_framer u_dut (
    .clk(clk), .rst(rst), .start(start), .addrToDigest(addrToDigest),
    .memAddr(memAddr), .memOutEn(memOutEn), .memData(memData),
    .outData(outData), .outValid(outValid), .outReady(outReady),
    .outFirst(outFirst), .outLast(outLast), .frameNum(frameNum),
    .busy(busy), .finish(finish), .crcOut(crcOut), .crcValid(crcValid)
  );

  digest_framer #(.RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .addrToDigest(10'd64),
    .memAddr(memAddr3), .memOutEn(memOutEn3), .memData(memData3),
    .outData(outData3), .outValid(outValid3), .outReady(outReady3),
    .outFirst(outFirst3), .outLast(outLast3), .frameNum(frameNum3),
    .busy(busy3), .finish(finish3), .crcOut(crcOut3), .crcValid(crcValid3)
  );

  // RAM models: data is seen RD_LATENCY edges after memOutEn is registered.
  logic [7:0] mem [1024];
  logic [7:0] p1 = '0, p2 = '0;
  assign memData = memOutEn ? mem[memAddr] : 8'hEE;
  always @(posedge clk) begin
    p1 <= memOutEn3 ? mem[memAddr3] : 8'hEE;
    p2 <= p1;
  end
  assign memData3 = p2;

  int errors = 0, checks = 0, cyc = 0, t0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_hs = 0, n_rd = 0, n_fin = 0, fin_cyc = 0, n_crcv = 0;
  logic [7:0] hs_data  [512];
  logic [1:0] hs_fl    [512];
  logic [1:0] hs_frame [512];
  logic [9:0] rd_addr  [512];
  logic [14:0] crc_log [64];
  int         n3 = 0, n_fin3 = 0;
  logic [7:0] d3 [64];
  int         c3 [64];

  always @(negedge clk) begin
    if (outValid && outReady) begin
      if (n_hs < 512) begin
        hs_data[n_hs]  <= outData;
        hs_fl[n_hs]    <= {outFirst, outLast};
        hs_frame[n_hs] <= frameNum;
      end
      n_hs <= n_hs + 1;
    end
    if (memOutEn) begin
      if (n_rd < 512) rd_addr[n_rd] <= memAddr;
      n_rd <= n_rd + 1;
    end
    if (finish) begin
      n_fin   <= n_fin + 1;
      fin_cyc <= cyc;
    end
    if (crcValid) begin
      if (n_crcv < 64) crc_log[n_crcv] <= crcOut;
      n_crcv <= n_crcv + 1;
    end
    if (outValid3 && outReady3) begin
      if (n3 < 64) begin
        d3[n3] <= outData3;
        c3[n3] <= cyc;
      end
      n3 <= n3 + 1;
    end
    if (finish3) n_fin3 <= n_fin3 + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_start(input logic [9:0] a);
    @(posedge clk); #1;
    addrToDigest = a;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_fin(input string nm, input int budget);
    int f0;
    f0 = n_fin;
    for (int k = 0; k < budget && n_fin == f0; k++) @(posedge clk);
    chk(nm, int'(n_fin != f0), 1);
    #1;
  endtask

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic [1:0] fl;
    logic [1:0] frame;
    logic [9:0] addr;
  } vec_t;
  vec_t vt [10];

  task automatic check_run(input string tag, input int h0, input int r0);
    bit ok;
    chk({tag, "_count"}, n_hs - h0, 32);
    for (int v = 0; v < 10; v++) begin
      int i;
      i = vt[v].idx;
      chk($sformatf("%s_b%0d_data", tag, i), int'(hs_data[h0 + i]), int'(vt[v].data));
      chk($sformatf("%s_b%0d_firstlast", tag, i), int'(hs_fl[h0 + i]), int'(vt[v].fl));
      chk($sformatf("%s_b%0d_frame", tag, i), int'(hs_frame[h0 + i]), int'(vt[v].frame));
      chk($sformatf("%s_b%0d_addr", tag, i), int'(rd_addr[r0 + i]), int'(vt[v].addr));
    end
    ok = 1'b1;
    for (int i = 0; i < 32; i++)
      if (hs_data[h0 + i] != 8'(i) || hs_fl[h0 + i] != {i % 8 == 0, i % 8 == 7}) ok = 1'b0;
    chk({tag, "_all_bytes"}, int'(ok), 1);
  endtask

  initial begin
    int h0, r0, f0, c0, stall;
    bit stable, ok;
    logic [11:0] snap;

    vt[0] = '{0,  8'h00, 2'b10, 2'd0, 10'd64};
    vt[1] = '{1,  8'h01, 2'b00, 2'd0, 10'd65};
    vt[2] = '{7,  8'h07, 2'b01, 2'd0, 10'd71};
    vt[3] = '{8,  8'h08, 2'b10, 2'd1, 10'd72};
    vt[4] = '{10, 8'h0A, 2'b00, 2'd1, 10'd74};
    vt[5] = '{15, 8'h0F, 2'b01, 2'd1, 10'd79};
    vt[6] = '{16, 8'h10, 2'b10, 2'd2, 10'd80};
    vt[7] = '{23, 8'h17, 2'b01, 2'd2, 10'd87};
    vt[8] = '{24, 8'h18, 2'b10, 2'd3, 10'd88};
    vt[9] = '{31, 8'h1F, 2'b01, 2'd3, 10'd95};

    for (int i = 0; i < 1024; i++) mem[i] = 8'hA5;
    for (int i = 0; i < 32; i++) begin
      mem[64 + i]            = 8'(i);
      mem[(1020 + i) % 1024] = 8'(8'h80 + i);
      mem[200 + i]           = 8'h00;
    end
    mem[207] = 8'h01;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", int'({memOutEn, outValid, outFirst, outLast, busy, finish, crcValid}), 0);
    chk("reset_values", int'(memAddr) + int'(outData) + int'(frameNum) + int'(crcOut), 0);
    rst = 1'b0;

    // Run 1: straight run, consumer always ready.
    h0 = n_hs; r0 = n_rd; f0 = n_fin; c0 = n_crcv;
    do_start(10'd64);
    chk("run1_busy", int'(busy), 1);
    wait_fin("run1_finish_seen", 300);
    // t0 is taken in the cycle before start is sampled, hence one more than the 97-cycle latency.
    chk("run1_finish_latency", fin_cyc - t0, 98);
    repeat (3) @(posedge clk);
    chk("run1_one_finish", n_fin - f0, 1);
    chk("run1_busy_after", int'(busy), 0);
    check_run("run1", h0, r0);
`ifdef FRAMER_CRC_EN
    chk("run1_crc_pulses", n_crcv - c0, 4);
`endif

    // Run 2: ready 1 low / 3 high, plus a 10-cycle stall on byte 0x0A.
    h0 = n_hs; r0 = n_rd; f0 = n_fin;
    stall = 0; stable = 1'b1; snap = '0;
    do_start(10'd64);
    for (int k = 0; k < 800 && n_fin == f0; k++) begin
      @(posedge clk); #1;
      if (outValid && outData == 8'h0A && stall < 10) begin
        outReady = 1'b0;
        if (stall == 0) snap = {outData, outFirst, outLast, frameNum};
        else if (snap != {outData, outFirst, outLast, frameNum}) stable = 1'b0;
        stall++;
      end else begin
        outReady = (cyc % 4 != 0);
      end
    end
    outReady = 1'b1;
    chk("run2_finish_seen", int'(n_fin != f0), 1);
    chk("run2_stall_len", stall, 10);
    chk("run2_stall_stable", int'(stable), 1);
    check_run("run2", h0, r0);

    // Run 3: base near top of address space wraps to 0.
    h0 = n_hs; r0 = n_rd;
    do_start(10'd1020);
    wait_fin("run3_finish_seen", 300);
    ok = 1'b1;
    for (int i = 0; i < 32; i++)
      if (rd_addr[r0 + i] != 10'((1020 + i) % 1024) || hs_data[h0 + i] != 8'(8'h80 + i)) ok = 1'b0;
    chk("run3_wrap_addr_data", int'(ok), 1);
    chk("run3_first_addr", int'(rd_addr[r0]), 1020);
    chk("run3_wrapped_addr", int'(rd_addr[r0 + 4]), 0);

    // Run 4: reset during frame 2 aborts, a new run restarts at byte 0.
    h0 = n_hs;
    do_start(10'd64);
    for (int k = 0; k < 200 && n_hs - h0 < 18; k++) @(posedge clk);
    #1;
    chk("run4_in_frame2", int'(frameNum), 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("run4_rst_flags", int'({memOutEn, outValid, outFirst, outLast, busy, finish, crcValid}), 0);
    chk("run4_rst_values", int'(memAddr) + int'(outData) + int'(frameNum) + int'(crcOut), 0);
    f0 = n_fin; c0 = n_hs;
    repeat (150) @(posedge clk);
    chk("run4_no_finish", n_fin - f0, 0);
    chk("run4_no_bytes", n_hs - c0, 0);
    h0 = n_hs; r0 = n_rd;
    do_start(10'd64);
    wait_fin("run4_restart_finish", 300);
    check_run("run4", h0, r0);

    // Run 5: start held high; second run starts only after the finish cycle.
    h0 = n_hs; f0 = n_fin;
    @(posedge clk); #1;
    addrToDigest = 10'd64;
    start = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (finish) begin
        ok = 1'b1;
        break;
      end
    end
    chk("run5_finish_seen", int'(ok), 1);
    chk("run5_busy_in_finish", int'(busy), 0);
    chk("run5_one_run_bytes", n_hs - h0, 32);
    @(posedge clk); #1;
    chk("run5_busy_next", int'(busy), 1);
    start = 1'b0;
    wait_fin("run5_second_finish", 300);
    repeat (120) @(posedge clk);
    chk("run5_two_runs_bytes", n_hs - h0, 64);
    chk("run5_two_finishes", n_fin - f0, 2);

    // Run 6: RD_LATENCY=3 instance, 5 cycles per byte.
    @(posedge clk); #1;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    for (int k = 0; k < 400 && n_fin3 == 0; k++) @(posedge clk);
    chk("lat3_finish_seen", n_fin3, 1);
    chk("lat3_count", n3, 32);
    ok = 1'b1;
    for (int i = 0; i < 32; i++) if (d3[i] != 8'(i)) ok = 1'b0;
    chk("lat3_data", int'(ok), 1);
    ok = 1'b1;
    for (int i = 0; i < 31; i++) if (c3[i + 1] - c3[i] != 5) ok = 1'b0;
    chk("lat3_spacing", int'(ok), 1);

`ifdef FRAMER_CRC_EN
    // CRC run: frame 0 is 00..00 01, the other frames are all zero.
    c0 = n_crcv;
    do_start(10'd200);
    wait_fin("crc_finish_seen", 300);
    repeat (3) @(posedge clk);
    chk("crc_pulses", n_crcv - c0, 4);
    chk("crc_frame0", int'(crc_log[c0]), 'h4599);
    chk("crc_frame1", int'(crc_log[c0 + 1]), 0);
    chk("crc_frame3", int'(crc_log[c0 + 3]), 0);
    chk("crc_hold", int'(crcOut), 0);
`else
    chk("crc_never_valid", n_crcv, 0);
    chk("crc_out_zero", int'(crcOut), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/digest_framer.md
Name: digest_framer

Overview:
Downstream of sha256. Once the hash core has written the 32-byte digest to RAM, this block reads it back byte by byte and splits it into 8-byte CAN payload frames. It presents the bytes as a valid/ready byte stream with frame delimiters to the CAN transmit path (buffer FIFO / CRC stage). It is the single RAM reader in the window between sha256 finish and frame transmission.

Parameters:
ADDR_WIDTH, 10, RAM address width
DATA_WIDTH, 8, RAM/stream byte width
DIGEST_BYTES, 32, bytes read per run
FRAME_BYTES, 8, payload bytes per CAN frame (DIGEST_BYTES must be a multiple of it)
RD_LATENCY, 1, cycles from memOutEn/memAddr registered to memData valid (1..4)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  level/pulse; sampled in IDLE to begin a run
addrToDigest  input  ADDR_WIDTH  base address of digest in RAM, latched on start
memAddr  output  ADDR_WIDTH  RAM read address
memOutEn  output  1  RAM output enable (read strobe)
memData  input  DATA_WIDTH  RAM read data
outData  output  DATA_WIDTH  stream byte
outValid  output  1  outData valid
outReady  input  1  consumer accepts byte when outValid&outReady
outFirst  output  1  current byte is byte 0 of a frame
outLast  output  1  current byte is last byte of a frame
frameNum  output  2  index of current frame (0..DIGEST_BYTES/FRAME_BYTES-1)
busy  output  1  high from accepted start until finish
finish  output  1  one-cycle pulse at run end
crcOut  output  15  frame CRC (see Optional Feature)
crcValid  output  1  one-cycle pulse with crcOut

Behaviour:
- Reset (rst=1 at posedge): state IDLE; all outputs 0; byte index, frame counter, latched base cleared. Reset mid-run aborts immediately; no finish pulse; any in-flight read data is discarded.
- All outputs are registered.
- FSM: IDLE -> ISSUE -> WAIT -> PRESENT -> (ISSUE | DONE) -> IDLE.
- IDLE: busy=0. On start=1, latch addrToDigest, idx=0, busy<=1, go ISSUE. start is ignored in every non-IDLE state.
- ISSUE: memAddr<=base+idx (mod 2^ADDR_WIDTH, wraps silently); memOutEn<=1 for exactly one cycle; go WAIT.
- WAIT: count RD_LATENCY cycles after the memOutEn cycle; on the final count, capture memData into outData, set outValid<=1, outFirst=(idx%FRAME_BYTES==0), outLast=(idx%FRAME_BYTES==FRAME_BYTES-1), frameNum=idx/FRAME_BYTES; go PRESENT.
- PRESENT: outData/outFirst/outLast/frameNum are held stable while outValid&!outReady (no limit on stall). On handshake: outValid<=0. If idx==DIGEST_BYTES-1 go DONE, else idx++ and go ISSUE.
- Throughput: one byte per (2+RD_LATENCY) cycles with outReady held high. A full run with RD_LATENCY=1 and outReady=1 takes 96 cycles from start to last handshake.
- DONE: finish<=1 for one cycle, busy<=0, go IDLE. start sampled in the finish cycle is ignored; it is accepted from the next cycle.
- memOutEn is never asserted outside ISSUE, so the RAM is free for other masters whenever memOutEn=0.
- outReady asserted while outValid=0 has no effect.

Optional Feature:
FRAMER_CRC_EN
- Defined: compute CAN CRC-15 (poly 0x4599, init 0, MSB first, bitwise: nxt=crc[14]^bit; crc=(crc<<1)&0x7FFF; if nxt crc^=0x4599) over each frame's payload bytes.
- Fold each byte in at its handshake; reset the accumulator at the outFirst handshake.
- One cycle after the outLast handshake: crcOut holds the frame CRC and crcValid pulses for 1 cycle. crcOut holds until the next crcValid.
- rst clears crcOut.
- Not defined: crcOut=0 and crcValid=0 permanently; no CRC logic is synthesised.

Test Plan:
- RAM[64..95]=0x00..0x1F, addrToDigest=64, outReady=1, start pulse: 32 bytes 0x00..0x1F in order; outFirst on 0x00,0x08,0x10,0x18; outLast on 0x07,0x0F,0x17,0x1F; frameNum 0..3; memAddr 64..95; finish is 1 cycle, 97 cycles after start.
- Same data, outReady toggling 1 low / 3 high plus a 10-cycle stall on byte 0x0A: no byte lost or duplicated; outData/outFirst/outLast stable through the stall.
- addrToDigest=1020 (ADDR_WIDTH=10): memAddr sequence 1020..1023, 0..27.
- rst asserted during frame 2: next cycle all outputs 0, no finish. A new start then reads from byte 0 again.
- start held high for the entire run: exactly one run; a second run begins only in the cycle after finish. RD_LATENCY=3: bytes still correct, 5 cycles per byte.
- FRAMER_CRC_EN: frame payload 00 00 00 00 00 00 00 01 -> crcOut=0x4599; all-zero frame -> crcOut=0x0000; crcValid pulses 4 times per run. Without macro: crcValid never asserts.
